// File: rtl/icache_pkg.sv
// Shared instruction-cache constants and refill FSM state encoding.
// Block geometry here must match the instruction cache line size.
package icache_pkg;

  localparam int BLOCK_WIDTH = 4;
  localparam int BLOCK_SIZE  = 2 ** BLOCK_WIDTH;
  localparam int RAM_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FETCH,
    DRAIN,
    DONE
  } refillStateT;

endpackage

// File: rtl/icache_refill_if.sv
// Miss / memory-port / block-delivery bundle of the icache refill unit.
// master = refill engine, slave = cache, arbiter and RAM side.
interface icache_refill_if #(
  parameter int BLOCK_WIDTH = icache_pkg::BLOCK_WIDTH
);

  localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;

  logic                   missIn;
  logic [31:0]            missAddrIn;
  logic                   memGrantIn;
  logic                   memReqOut;
  logic [31:0]            ramAddrOut;
  logic [7:0]             ramDataIn;
  logic                   memDataValid;
  logic [31:BLOCK_WIDTH]  memAddr;
  logic [BLOCK_SIZE*8-1:0] memDataOut;

  modport master (
    input  missIn, missAddrIn, memGrantIn, ramDataIn,
    output memReqOut, ramAddrOut, memDataValid,
    output memAddr, memDataOut
  );

  modport slave (
    output missIn, missAddrIn, memGrantIn, ramDataIn,
    input  memReqOut, ramAddrOut, memDataValid,
    input  memAddr, memDataOut
  );

endinterface

// File: rtl/icache_refill_block_assembler.sv
// Byte-lane register that assembles one cache block little-endian.
// Lanes are written one at a time by index; clrIn zeroes the block.
module block_assembler #(
  parameter int LANES = 16,
  parameter int IDXW  = 4
) (
  input  logic               clkIn,
  input  logic               clrIn,
  input  logic               weIn,
  input  logic [IDXW-1:0]    laneIn,
  input  logic [7:0]         byteIn,
  output logic [LANES*8-1:0] blockOut
);

  always_ff @(posedge clkIn) begin
    if (clrIn) begin
      blockOut <= '0;
    end else if (weIn) begin
      blockOut[laneIn*8 +: 8] <= byteIn;
    end
  end

endmodule

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: byte-wide RAM refill of one block.
// Optional counters refillCount/stallCycles under ICACHE_REFILL_STATS_EN.
module icache_refill #(
  parameter int BLOCK_WIDTH = icache_pkg::BLOCK_WIDTH
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        flushIn,
`ifdef ICACHE_REFILL_STATS_EN
  output logic [31:0] refillCount,
  output logic [31:0] stallCycles,
`endif
  icache_refill_if.master bus
);

  import icache_pkg::*;

  localparam int LANES = 2 ** BLOCK_WIDTH;

  refillStateT state, stateNext;

  logic [BLOCK_WIDTH-1:0] cnt;
  logic [31:BLOCK_WIDTH]  base;
  logic                   laneWe;
  logic                   blkClr;
  logic [BLOCK_WIDTH-1:0] laneIdx;
  logic                   reqNext;
  logic [LANES*8-1:0]     lanes;
  logic [LANES*8-1:0]     blockFinal;

  // Data lags its address by the RAM latency, so lane = cnt - latency.
  always_comb begin
    stateNext = state;
    laneWe    = 1'b0;
    blkClr    = 1'b0;
    laneIdx   = cnt - BLOCK_WIDTH'(RAM_LATENCY);
    unique case (state)
      IDLE: begin
        if (bus.missIn && !flushIn) stateNext = REQ;
      end
      REQ: begin
        blkClr = bus.memGrantIn;
        if (flushIn)             stateNext = IDLE;
        else if (bus.memGrantIn) stateNext = FETCH;
      end
      FETCH: begin
        laneWe = (cnt != '0);
        if (flushIn)         stateNext = IDLE;
        else if (cnt == '1)  stateNext = DRAIN;
      end
      DRAIN: begin
        laneWe    = 1'b1;
        stateNext = flushIn ? IDLE : DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    reqNext = (stateNext == REQ) || (stateNext == FETCH) ||
              (stateNext == DRAIN);
  end

  always_comb begin
    blockFinal = lanes;
    blockFinal[LANES*8-1 -: 8] = bus.ramDataIn;
  end

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      state            <= IDLE;
      cnt              <= '0;
      base             <= '0;
      bus.memReqOut    <= 1'b0;
      bus.memDataValid <= 1'b0;
      bus.ramAddrOut   <= '0;
      bus.memAddr      <= '0;
      bus.memDataOut   <= '0;
    end else begin
      state            <= stateNext;
      bus.memReqOut    <= reqNext;
      bus.memDataValid <= (stateNext == DONE);
      if (state == IDLE && stateNext == REQ) begin
        base <= bus.missAddrIn[31:BLOCK_WIDTH];
      end
      if (state == REQ && stateNext == FETCH) begin
        cnt            <= '0;
        bus.ramAddrOut <= {base, {BLOCK_WIDTH{1'b0}}};
      end
      if (state == FETCH) begin
        cnt <= cnt + 1'b1;
        if (stateNext == FETCH) begin
          bus.ramAddrOut <= {base, cnt + 1'b1};
        end
      end
      if (stateNext == DONE) begin
        bus.memAddr    <= base;
        bus.memDataOut <= blockFinal;
      end
    end
  end

  block_assembler #(
    .LANES (LANES),
    .IDXW  (BLOCK_WIDTH)
  ) u_asm (
    .clkIn    (clkIn),
    .clrIn    (blkClr),
    .weIn     (laneWe),
    .laneIn   (laneIdx),
    .byteIn   (bus.ramDataIn),
    .blockOut (lanes)
  );

`ifdef ICACHE_REFILL_STATS_EN
  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      refillCount <= '0;
      stallCycles <= '0;
    end else begin
      if (bus.memDataValid && refillCount != '1) begin
        refillCount <= refillCount + 1'b1;
      end
      if (state != IDLE && stallCycles != '1) begin
        stallCycles <= stallCycles + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Randomized + directed bench for icache_refill against a timeline model.
// Define ICACHE_REFILL_STATS_EN to also check the refill statistics.
module tb_icache_refill;

  localparam int BW = 4;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic resetN;
  logic flush;

  always #5 clk = ~clk;

  icache_refill_if #(.BLOCK_WIDTH(BW)) bus ();

`ifdef ICACHE_REFILL_STATS_EN
  logic [31:0] refillCount;
  logic [31:0] stallCycles;
`endif

  icache_refill #(.BLOCK_WIDTH(BW)) dut (
    .clkIn       (clk),
    .resetIn     (resetN),
    .flushIn     (flush),
`ifdef ICACHE_REFILL_STATS_EN
    .refillCount (refillCount),
    .stallCycles (stallCycles),
`endif
    .bus         (bus)
  );

  int nVec = 0;
  int nErr = 0;
  int cyc = 0;
  int pulses = 0;
  bit hashEn = 1'b0;
  int gDelay = 0;
  int reqAge = 0;
  logic [31:0] pendAddr = '0;

  function automatic logic [7:0] ramByte(input logic [31:0] a);
    logic [7:0] h;
    h = a[15:8] + a[23:16] * 8'd3 + a[31:24] + 8'h5A;
    return hashEn ? (a[7:0] ^ h) : a[7:0];
  endfunction

  function automatic logic [127:0] blockOf(input logic [27:0] b);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < NB; k++) r[8*k +: 8] = ramByte({b, 4'(k)});
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // RAM answers one cycle after the address; arbiter grants after gDelay
  always @(negedge clk) pendAddr = bus.ramAddrOut;

  always @(posedge clk) begin
    #1;
    bus.ramDataIn = ramByte(pendAddr);
    if (bus.memReqOut === 1'b1) begin
      bus.memGrantIn = bus.memGrantIn | (reqAge >= gDelay);
      reqAge++;
    end else begin
      bus.memGrantIn = 1'b0;
      reqAge = 0;
    end
  end

  // Timeline model: refill from REQ cycle g, address k at g+1+k, pulse at g+18
  bit          armed = 1'b0;
  bit          act = 1'b0;
  int          g = -1;
  logic [27:0] mBase = '0;
  logic [31:0] hAddr = '0;
  logic [27:0] hMem = '0;
  logic [127:0] hData = '0;
  logic [31:0] mRef = '0;
  logic [31:0] mStall = '0;

  always @(negedge clk) begin : cmp
    logic eReq;
    logic eValid;
    logic [31:0] eAddr;
    int k;
    cyc++;
    eValid = act && g >= 0 && cyc == g + NB + 2;
    eReq   = act && (g < 0 || cyc <= g + NB + 1);
    eAddr  = hAddr;
    if (act && g >= 0 && cyc >= g + 1) begin
      k = cyc - g - 1;
      if (k > NB - 1) k = NB - 1;
      eAddr = {mBase, 4'(k)};
    end
    if (eValid) begin
      hMem  = mBase;
      hData = blockOf(mBase);
    end
    if (bus.memDataValid === 1'b1) pulses++;
    if (armed) begin
      chk("memReqOut", 128'(bus.memReqOut), 128'(eReq));
      chk("memDataValid", 128'(bus.memDataValid), 128'(eValid));
      chk("ramAddrOut", 128'(bus.ramAddrOut), 128'(eAddr));
      chk("memAddr", 128'(bus.memAddr), 128'(hMem));
      chk("memDataOut", bus.memDataOut, hData);
`ifdef ICACHE_REFILL_STATS_EN
      chk("refillCount", 128'(refillCount), 128'(mRef));
      chk("stallCycles", 128'(stallCycles), 128'(mStall));
`endif
    end
    if (!resetN) begin
      armed = 1'b1;
      act = 1'b0;
      hAddr = '0;
      hMem = '0;
      hData = '0;
      mRef = '0;
      mStall = '0;
    end else begin
      if (act && mStall != 32'hFFFF_FFFF) mStall++;
      if (eValid && mRef != 32'hFFFF_FFFF) mRef++;
      hAddr = eAddr;
      if (act) begin
        if (eValid) act = 1'b0;
        else if (flush) act = 1'b0;
        else if (g < 0 && bus.memGrantIn) g = cyc;
      end else if (bus.missIn && !flush) begin
        act = 1'b1;
        mBase = bus.missAddrIn[31:4];
        g = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (act && n < 200) begin
      tick();
      n++;
    end
    chk("idle timeout", 128'(act), 128'(0));
  endtask

  task automatic refill(input logic [31:0] a, input int d,
                        output int lat, output logic [27:0] ma,
                        output logic [127:0] md, output logic [31:0] fa);
    int t0;
    int t1;
    t0 = -1;
    t1 = -1;
    ma = '0;
    md = '0;
    fa = '0;
    waitIdle();
    gDelay = d;
    bus.missIn = 1'b1;
    bus.missAddrIn = a;
    tick();
    bus.missIn = 1'b0;
    for (int n = 0; n < 100 && t1 < 0; n++) begin
      @(negedge clk);
      if (t0 < 0 && bus.memReqOut && bus.memGrantIn) t0 = n;
      if (t0 >= 0 && n == t0 + 1) fa = bus.ramAddrOut;
      if (bus.memDataValid === 1'b1) begin
        t1 = n;
        ma = bus.memAddr;
        md = bus.memDataOut;
      end
    end
    lat = (t1 < 0) ? -1 : t1 - t0;
    tick();
  endtask

  initial begin
    int lat;
    int p0;
    logic [27:0] ma;
    logic [127:0] md;
    logic [31:0] fa;
    bus.missIn = 1'b0;
    bus.missAddrIn = '0;
    bus.memGrantIn = 1'b0;
    bus.ramDataIn = '0;
    flush = 1'b0;
    resetN = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    @(negedge clk);
    chk("rst memReqOut", 128'(bus.memReqOut), 128'(0));
    chk("rst memDataOut", bus.memDataOut, 128'(0));
    chk("rst ramAddrOut", 128'(bus.ramAddrOut), 128'(0));
    tick();

    refill(32'h0000_1234, 0, lat, ma, md, fa);
    chk("t1 latency", 128'(lat), 128'(18));
    chk("t1 memAddr", 128'(ma), 128'(28'h000_0123));
    chk("t1 block", md, 128'h3F3E3D3C3B3A39383736353433323130);
    chk("t1 first addr", 128'(fa), 128'(32'h0000_1230));

    refill(32'hFFFF_FFF7, 5, lat, ma, md, fa);
    chk("t2 latency", 128'(lat), 128'(18));
    chk("wrap block", md, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);

    waitIdle();
    gDelay = 0;
    bus.missIn = 1'b1;
    bus.missAddrIn = 32'h0000_4000;
    tick();
    bus.missIn = 1'b0;
    repeat (8) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("t3 k7 addr", 128'(bus.ramAddrOut), 128'(32'h0000_4007));
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("t3 req drop", 128'(bus.memReqOut), 128'(0));
    refill(32'h0000_0080, 0, lat, ma, md, fa);
    chk("t3 memAddr", 128'(ma), 128'(28'h000_0008));
    chk("t3 block", md, 128'h8F8E8D8C8B8A89888786858483828180);

    waitIdle();
    bus.missIn = 1'b1;
    bus.missAddrIn = 32'h0000_5550;
    tick();
    bus.missIn = 1'b0;
    repeat (5) tick();
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    @(negedge clk);
    chk("t4 req", 128'(bus.memReqOut), 128'(0));
    chk("t4 addr", 128'(bus.ramAddrOut), 128'(0));
    chk("t4 block", bus.memDataOut, 128'(0));
    refill(32'h00AB_CDE4, 1, lat, ma, md, fa);
    chk("t4 memAddr", 128'(ma), 128'(28'h00A_BCDE));

    waitIdle();
    p0 = pulses;
    gDelay = 0;
    bus.missIn = 1'b1;
    bus.missAddrIn = 32'h0000_3000;
    repeat (20) tick();
    bus.missAddrIn = 32'h0000_2000;
    tick();
    bus.missIn = 1'b0;
    @(negedge clk);
    chk("t5 second req", 128'(bus.memReqOut), 128'(1));
    tick();
    waitIdle();
    chk("t5 pulses", 128'(pulses - p0), 128'(2));
    chk("t5 memAddr", 128'(bus.memAddr), 128'(28'h000_0200));

`ifdef ICACHE_REFILL_STATS_EN
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    repeat (3) refill(32'h0000_6000, 2, lat, ma, md, fa);
    chk("t6 refillCount", 128'(refillCount), 128'(3));
    chk("t6 stallCycles", 128'(stallCycles), 128'(63));
`endif

    hashEn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.missIn = ($urandom % 5) == 0;
      bus.missAddrIn = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16))
                                           : $urandom;
      flush = ($urandom % 50) == 0;
      resetN = ($urandom % 400) != 0;
      if ($urandom % 30 == 0) gDelay = $urandom % 4;
      tick();
    end
    bus.missIn = 1'b0;
    flush = 1'b0;
    resetN = 1'b1;
    waitIdle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
